// File: rtl/cmploader.sv
// rtl/cmploader.sv - host-side bitmap loader and result holder for the compare accelerator
//
// Collects NWORDS words of WORDW bits into a BMPW-bit bitmap, strobes it to the
// accelerator with a one-cycle wren, waits for a rising edge on cmpdone (or a
// TIMEOUT-cycle limit) and holds the score until the host acknowledges it.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             begin a load (sampled in IDLE only)
//   wordin/wordvalid  input word stream; wordready high while loading
//   bitmap, wren      assembled bitmap and one-cycle write strobe to accelerator
//   cmpdone/cmpresult accelerator done level and 13-bit score
//   result/timeout    latched score and timeout flag, valid with resultvalid
//   resultack         host consumed the result
//   busy              high in every state except IDLE

module cmploader #(
    parameter int WORDW   = 16,
    parameter int BMPW    = 1536,
    parameter int NWORDS  = BMPW / WORDW,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORDW-1:0]  wordin,
    input  logic              wordvalid,
    output logic              wordready,
    output logic [BMPW-1:0]   bitmap,
    output logic              wren,
    input  logic              cmpdone,
    input  logic [12:0]       cmpresult,
    output logic [12:0]       result,
    output logic              resultvalid,
    input  logic              resultack,
    output logic              timeout,
    output logic              busy
);

    localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] LASTWORD = WCW'(NWORDS - 1);
    localparam logic [TCW-1:0] LASTWAIT = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        WAIT,
        HOLD
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [WCW-1:0] wcnt;
    logic [TCW-1:0] tcnt;
    logic           doneprev;
    logic           doneedge;
    logic           waitlast;

    // Only a fresh rising edge counts: a done level left high by a previous
    // compare must fall and rise again before it is accepted.
    assign doneedge = cmpdone && !doneprev;
    assign waitlast = (tcnt == LASTWAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        wordready   = 1'b0;
        wren        = 1'b0;
        resultvalid = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wordready = 1'b1;
                if (wordvalid && (wcnt == LASTWORD)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wren    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion and timeout both leave for HOLD; which one wins
                // is decided in the datapath below.
                if (doneedge || waitlast) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                resultvalid = 1'b1;
                if (resultack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     <= '0;
            tcnt     <= '0;
            doneprev <= 1'b0;
            bitmap   <= '0;
            result   <= '0;
            timeout  <= 1'b0;
        end else begin
            doneprev <= cmpdone;
            case (state)
                IDLE: begin
                    if (start) begin
                        wcnt <= '0;
                    end
                end
                LOAD: begin
                    if (wordvalid) begin
                        // Constant-index slices keep the word steering a plain
                        // decoder on wcnt.
                        for (int k = 0; k < NWORDS; k++) begin
                            if (wcnt == WCW'(k)) begin
                                bitmap[k*WORDW +: WORDW] <= wordin;
                            end
                        end
                        wcnt <= wcnt + 1'b1;
                    end
                end
                WRITE: begin
                    tcnt <= '0;
                end
                WAIT: begin
                    if (doneedge) begin
                        result  <= cmpresult;
                        timeout <= 1'b0;
                    end else if (waitlast) begin
                        result  <= 13'h1FFF;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmploader.sv
// tb/tb_cmploader.sv - randomized self-checking bench for cmploader with an in-bench model

module tb_cmploader;

    localparam int WORDW = 16;
    localparam int BMPW  = 1536;
    localparam int NW    = BMPW / WORDW;
    localparam int TO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WORDW-1:0]  wordin = '0;
    logic              wordvalid = 1'b0;
    logic              wordready;
    logic [BMPW-1:0]   bitmap;
    logic              wren;
    logic              cmpdone = 1'b0;
    logic [12:0]       cmpresult = '0;
    logic [12:0]       result;
    logic              resultvalid;
    logic              resultack = 1'b0;
    logic              timeout;
    logic              busy;

    cmploader #(
        .WORDW  (WORDW),
        .BMPW   (BMPW),
        .NWORDS (NW),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wordin     (wordin),
        .wordvalid  (wordvalid),
        .wordready  (wordready),
        .bitmap     (bitmap),
        .wren       (wren),
        .cmpdone    (cmpdone),
        .cmpresult  (cmpresult),
        .result     (result),
        .resultvalid(resultvalid),
        .resultack  (resultack),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bmp(input string name, input logic [BMPW-1:0] exp);
        int fi;
        total++;
        if (bitmap !== exp) begin
            bad++;
            fi = -1;
            for (int i = NW - 1; i >= 0; i--) begin
                if (bitmap[i*WORDW +: WORDW] !== exp[i*WORDW +: WORDW]) fi = i;
            end
            if (bad <= 40 && fi >= 0)
                $display("FAIL %s: word %0d got %h want %h (cycle %0d)", name, fi,
                         bitmap[fi*WORDW +: WORDW], exp[fi*WORDW +: WORDW], cyc);
        end
    endtask

    // Behavioural model: what the host should see, phrased as the five phases
    // of a compare and the number of words / waiting cycles spent in them.
    typedef enum {M_IDLE, M_LOAD, M_WRITE, M_WAIT, M_HOLD} mphase_t;
    mphase_t         mm;
    int              mn;
    int              mwc;
    logic [BMPW-1:0] mbmp;
    logic [12:0]     mres;
    logic            mto;
    logic            mprev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm    <= M_IDLE;
            mn    <= 0;
            mwc   <= 0;
            mbmp  <= '0;
            mres  <= '0;
            mto   <= 1'b0;
            mprev <= 1'b0;
        end else begin
            mprev <= cmpdone;
            case (mm)
                M_IDLE:  if (start) begin mm <= M_LOAD; mn <= 0; end
                M_LOAD:  if (wordvalid) begin
                             mbmp[mn*WORDW +: WORDW] <= wordin;
                             mn <= mn + 1;
                             if (mn + 1 == NW) mm <= M_WRITE;
                         end
                M_WRITE: begin mm <= M_WAIT; mwc <= 0; end
                M_WAIT:  if (cmpdone && !mprev) begin
                             mres <= cmpresult; mto <= 1'b0; mm <= M_HOLD;
                         end else begin
                             mwc <= mwc + 1;
                             if (mwc + 1 == TO) begin mres <= 13'h1FFF; mto <= 1'b1; mm <= M_HOLD; end
                         end
                M_HOLD:  if (resultack) mm <= M_IDLE;
                default: mm <= M_IDLE;
            endcase
        end
    end

    int   xfers = 0;
    int   last_xfer = 0;
    int   wrens = 0;
    int   wren_cyc = 0;
    int   rv_cyc = 0;
    logic rvprev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("wordready", wordready, mm == M_LOAD);
            chk("wren", wren, mm == M_WRITE);
            chk("busy", busy, mm != M_IDLE);
            chk("resultvalid", resultvalid, mm == M_HOLD);
            chk("result", result, mres);
            chk("timeout", timeout, mto);
            chk_bmp("bitmap", mbmp);
            if (wordvalid && wordready) begin
                xfers     <= xfers + 1;
                last_xfer <= cyc;
            end
            if (wren) begin
                wrens    <= wrens + 1;
                wren_cyc <= cyc;
            end
            if (resultvalid && !rvprev) rv_cyc <= cyc;
            rvprev <= resultvalid;
        end
    end

    int c0 = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    // vmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
    task automatic load(input int vmode, input int nmax, input int spulse, input bit seq);
        int k = 0;
        int g = 0;
        bit acc;
        while (k < nmax && g < 2000) begin
            case (vmode)
                0:       wordvalid = 1'b1;
                1:       wordvalid = (g % 2 == 0);
                default: wordvalid = ($urandom_range(3) != 0);
            endcase
            wordin = seq ? 16'(k + 1) : 16'($urandom);
            start  = (k == spulse);
            acc    = wordvalid && wordready;
            tick();
            if (acc) k++;
            g++;
        end
        wordvalid = 1'b0;
        start     = 1'b0;
        chk("load_words", k, nmax);
    endtask

    // Called in the WRITE cycle; leaves the bench in the first HOLD cycle.
    task automatic wait_result(input int ddly, input logic [12:0] r, input bit useedge);
        int g = 0;
        tick();
        repeat (ddly) tick();
        if (useedge) begin
            cmpresult = r;
            cmpdone   = 1'b1;
            tick();
            cmpdone   = 1'b0;
        end
        while (!resultvalid && g < TO + 20) begin
            tick();
            g++;
        end
        chk("result_seen", resultvalid, 1);
    endtask

    task automatic ack();
        repeat ($urandom_range(0, 2)) tick();
        resultack = 1'b1;
        tick();
        resultack = 1'b0;
        chk("ack_idle_busy", busy, 0);
        chk("ack_idle_rv", resultvalid, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wren"}, wren, 0);
        chk({tag, "_wordready"}, wordready, 0);
        chk({tag, "_rv"}, resultvalid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_bitmap"}, bitmap == '0, 1);
    endtask

    int x0;
    int w0;
    logic [12:0] r;

    initial begin
        #1;
        chk_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();

        // full streaming load with sequential words
        w0 = wrens;
        do_start();
        load(0, NW, -1, 1'b1);
        tick();
        chk("stream_wren_cycle", wren_cyc - c0, 97);
        chk("stream_wren_count", wrens - w0, 1);
        chk("stream_bmp_lo", bitmap[15:0], 16'h0001);
        chk("stream_bmp_hi", bitmap[1535:1520], 16'h0060);
        cmpresult = 13'h0A5C;
        cmpdone   = 1'b1;
        tick();
        cmpdone   = 1'b0;
        chk("stream_rv", resultvalid, 1);
        chk("stream_result", result, 13'h0A5C);
        chk("stream_timeout", timeout, 0);
        tick();
        chk("stream_rv_cycle", rv_cyc - c0, 99);
        ack();

        // stalled load
        x0 = xfers;
        w0 = wrens;
        do_start();
        load(1, NW, -1, 1'b0);
        wait_result($urandom_range(0, 4), 13'($urandom), 1'b1);
        chk("stall_xfers", xfers - x0, 96);
        chk("stall_wren_count", wrens - w0, 1);
        chk("stall_wren_after_last", wren_cyc - last_xfer, 1);
        ack();

        // stale done level held through load and write
        cmpdone = 1'b1;
        tick();
        do_start();
        load(2, NW, -1, 1'b0);
        tick();
        tick();
        tick();
        chk("stale_no_rv", resultvalid, 0);
        cmpdone = 1'b0;
        tick();
        cmpdone   = 1'b1;
        cmpresult = 13'h1234;
        tick();
        cmpdone   = 1'b0;
        chk("stale_rv", resultvalid, 1);
        chk("stale_result", result, 13'h1234);
        ack();

        // timeout
        do_start();
        load(0, NW, -1, 1'b0);
        wait_result(0, 13'h0, 1'b0);
        chk("to_result", result, 13'h1FFF);
        chk("to_flag", timeout, 1);
        tick();
        chk("to_latency", rv_cyc - (wren_cyc + 1), TO);
        ack();

        // reset mid-load
        do_start();
        load(0, 40, -1, 1'b0);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        #1;
        rst = 1'b0;
        do_start();
        load(0, NW, -1, 1'b0);
        tick();
        chk("midreset_wren_cycle", wren_cyc - c0, 97);
        r = 13'($urandom);
        cmpresult = r;
        cmpdone   = 1'b1;
        tick();
        cmpdone   = 1'b0;
        chk("midreset_result", result, r);
        ack();

        // start pulses during LOAD and HOLD are ignored
        x0 = xfers;
        w0 = wrens;
        do_start();
        load(2, NW, 30, 1'b0);
        wait_result(2, 13'h0777, 1'b1);
        chk("ign_xfers", xfers - x0, 96);
        chk("ign_wren_count", wrens - w0, 1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("ign_hold_rv", resultvalid, 1);
        chk("ign_hold_result", result, 13'h0777);
        ack();

        // random operations, some of which time out
        for (int it = 0; it < 6; it++) begin
            do_start();
            load($urandom_range(0, 2), NW, -1, 1'b0);
            wait_result($urandom_range(0, 11), 13'($urandom), 1'b1);
            ack();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmploader.md
# cmploader

Host-side writer for the compare accelerator: collects a 1536-bit symbol bitmap from a 16-bit word stream, presents it on the accelerator's bitmap bus with a one-cycle write-enable pulse, then waits for the accelerator's completion and holds its 13-bit score for the host until acknowledged. It sits between the processor/memory word interface and the accelerator's `bitmap`/`wren`/`result`/`done` ports, and owns the load → compare → readback sequence.

## Interface
- `WORDW`, 16: input word width; must divide `BMPW`.
- `BMPW`, 1536: bitmap width (64 columns × 24 rows).
- `NWORDS`, `BMPW/WORDW` (96): words per bitmap.
- `TIMEOUT`, 4096: maximum cycles to wait for completion.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `wordin`  in  `WORDW`  bitmap data word.
- `wordvalid`  in  1  `wordin` valid.
- `wordready`  out  1  loader accepts a word this cycle.
- `bitmap`  out  `BMPW`  assembled bitmap to accelerator.
- `wren`  out  1  one-cycle bitmap write strobe to accelerator.
- `cmpdone`  in  1  accelerator `done`.
- `cmpresult`  in  13  accelerator `result`.
- `result`  out  13  latched score.
- `resultvalid`  out  1  `result`/`timeout` valid for host.
- `resultack`  in  1  host consumed result.
- `timeout`  out  1  compare did not finish within `TIMEOUT`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, WRITE, WAIT, HOLD.
- IDLE: `wordready`=0. `start`=1 → LOAD; word counter cleared.
- LOAD: `wordready`=1. Transfer occurs when `wordvalid`&&`wordready`; word k is written to `bitmap[k*WORDW +: WORDW]` (word 0 = LSBs), and the counter increments. Accepting word `NWORDS-1` → WRITE. `wordvalid` gaps stall the load without limit. `start` is ignored.
- WRITE: `wren`=1 for exactly one cycle → WAIT. The wait counter is cleared.
- WAIT: completion is a `cmpdone` rising edge, i.e. `cmpdone`=1 with registered previous `cmpdone`=0. The previous-value register updates in every state, so a `done` level left high from an earlier compare is not accepted.
  - On completion: latch `cmpresult` → `result`, clear `timeout` → HOLD.
  - Otherwise the wait counter increments. When it reaches `TIMEOUT-1`: `result`=13'h1FFF, `timeout`=1 → HOLD.
  - If completion and timeout occur in the same cycle, completion wins.
- HOLD: `resultvalid`=1; `result` and `timeout` are held. `resultack`=1 → IDLE, with `resultvalid` low the next cycle. `start` is ignored.
- `bitmap` is held between operations and is overwritten word by word during the next LOAD. The accelerator samples it only on `wren`.
- Reset value is 0 for all outputs and registers (including `bitmap`, `result`, both counters and the previous-`cmpdone` register); the state resets to IDLE.
- Reset asserted mid-operation aborts immediately; the next load restarts at word 0.

## Timing
- `start` in cycle 0 → LOAD from cycle 1 (`wordready`=1, `busy`=1).
- With `wordvalid` held high, words are accepted in cycles 1..96, `wren`=1 in cycle 97, and WAIT starts in cycle 98.
- `cmpdone` rising edge seen in cycle t → `resultvalid`=1 from cycle t+1, with `result` = the `cmpresult` value sampled in cycle t.
- Timeout: `resultvalid`=1 exactly `TIMEOUT` cycles after entering WAIT when no edge is seen.
- `resultack` in cycle u while in HOLD → IDLE in u+1, with `busy`=0 and `resultvalid`=0. `start` is accepted from u+1.
- Latency from `start` to `wren` is `NWORDS`+1 cycles minimum.
- `wren` is never asserted outside WRITE and never for more than one cycle per load.

## Test plan
- Full streaming load:
  - Stimulus: `start`, then words k = 16'(k+1) back-to-back.
  - Required: `wren` high only in cycle 97; `bitmap[15:0]`=16'h0001, `bitmap[1535:1520]`=16'h0060.
  - Then drive a `cmpdone` edge with `cmpresult`=13'h0A5C: `result`=13'h0A5C, `timeout`=0, `resultvalid` one cycle later.
- Stalled load:
  - Stimulus: toggle `wordvalid` every other cycle.
  - Required: exactly 96 transfers, `wren` in the cycle after the 96th, no words lost or duplicated.
- Stale done:
  - Stimulus: hold `cmpdone`=1 throughout the load and WRITE.
  - Required: no completion until `cmpdone` falls and rises again.
- Timeout (`TIMEOUT`=8):
  - Stimulus: no `cmpdone` edge.
  - Required: `resultvalid` 8 cycles after entering WAIT, `result`=13'h1FFF, `timeout`=1. After `resultack`, IDLE with `busy`=0.
- Reset mid-operation:
  - Stimulus: assert `rst` after 40 words.
  - Required: all outputs 0 asynchronously. A following `start` and 96 words produce `wren` at cycle 97 relative to the new `start`.
- Ignored start:
  - Stimulus: pulse `start` during LOAD and during HOLD.
  - Required: no state change or counter reset. After `resultack`, a new `start` begins a fresh load.
